// File: rtl/sys_addr_map_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_addr_map_pkg
// Description : Shared types and constants for the CPU address decoder.
//               Contents: region enum, one-hot select bit indices, sequencer
//               state enum, fixed FFxx address constants, and a helper that
//               converts a region code to its one-hot select vector.
// Revision    : 1.0 - initial release
// ============================================================================
package sys_addr_map_pkg;

    // Region codes double as the bit position in the one-hot select vector.
    typedef enum logic [2:0] {
        REG_BOOT  = 3'd0,
        REG_HRAM  = 3'd1,
        REG_IFR   = 3'd2,
        REG_TIMER = 3'd3,
        REG_IE    = 3'd4,
        REG_IO    = 3'd5,
        REG_EXT   = 3'd6
    } region_t;

    localparam int SEL_W     = 7;
    localparam int SEL_BOOT  = 0;
    localparam int SEL_HRAM  = 1;
    localparam int SEL_IFR   = 2;
    localparam int SEL_TIMER = 3;
    localparam int SEL_IE    = 4;
    localparam int SEL_IO    = 5;
    localparam int SEL_EXT   = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int unsigned c_ifr_addr  = 32'h0000_FF0F;
    localparam int unsigned c_tim_lo    = 32'h0000_FF04;
    localparam int unsigned c_tim_hi    = 32'h0000_FF07;
    localparam int unsigned c_ie_addr   = 32'h0000_FFFF;
    localparam int unsigned c_io_lo     = 32'h0000_FF00;
    localparam int unsigned c_io_hi     = 32'h0000_FFFF;
    localparam int unsigned c_lock_addr = 32'h0000_FF50;
    localparam int unsigned c_test_addr = 32'h0000_FF60;
    localparam int unsigned c_hram_base = 32'h0000_FF80;
    localparam int unsigned c_hram_end  = 32'h0000_FFFE;

    function automatic logic [SEL_W-1:0] region_to_sel(input region_t r);
        return {{(SEL_W-1){1'b0}}, 1'b1} << r;
    endfunction

endpackage : sys_addr_map_pkg
`default_nettype wire

// File: rtl/sys_addr_map_if.sv
`default_nettype none
// ============================================================================
// Module      : sys_addr_map_if
// Description : CPU-side request/ack bus of the address decoder.
//               master : drives req, we, a, wdata, test_en
//               slave  : drives ack, sel, rd_stb, wr_stb, rdata, rdata_oe,
//                        boot_locked, test_bits
// Revision    : 1.0 - initial release
// ============================================================================
interface sys_addr_map_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] wdata;
    logic          test_en;
    logic          ack;
    logic [6:0]    sel;
    logic          rd_stb;
    logic          wr_stb;
    logic [DW-1:0] rdata;
    logic          rdata_oe;
    logic          boot_locked;
    logic [1:0]    test_bits;

    modport master (
        output req, we, a, wdata, test_en,
        input  ack, sel, rd_stb, wr_stb, rdata, rdata_oe, boot_locked, test_bits
    );

    modport slave (
        input  req, we, a, wdata, test_en,
        output ack, sel, rd_stb, wr_stb, rdata, rdata_oe, boot_locked, test_bits
    );
endinterface : sys_addr_map_if
`default_nettype wire

// File: rtl/sys_addr_region.sv
`default_nettype none
// ============================================================================
// Module      : sys_addr_region
// Description : Combinational address-to-region classifier. Shared with the
//               DMA arbiter, so it carries the full parameter set.
//   a           in  AW  address to classify
//   boot_locked in  1   when set, boot windows fall through to lower priority
//   region      out 3   region code (region_t)
// Revision    : 1.0 - initial release
// ============================================================================
module sys_addr_region
    import sys_addr_map_pkg::*;
#(
    parameter int          AW         = 16,
    parameter int unsigned BOOT_SIZE  = 256,
    parameter int unsigned BOOT2_BASE = 'h0200,
    parameter int unsigned BOOT2_SIZE = 0,
    parameter int unsigned HRAM_BASE  = c_hram_base,
    parameter int unsigned HRAM_END   = c_hram_end
) (
    input  logic [AW-1:0] a,
    input  logic          boot_locked,
    output region_t       region
);

    // One extra bit so window ends near the top of the map cannot overflow.
    localparam logic [AW:0] BOOT1_LIM = (AW+1)'(BOOT_SIZE);
    localparam logic [AW:0] BOOT2_LO  = (AW+1)'(BOOT2_BASE);
    localparam logic [AW:0] BOOT2_HI  = (AW+1)'(BOOT2_BASE) + (AW+1)'(BOOT2_SIZE) - 1'b1;
    localparam logic [AW:0] HRAM_LO   = (AW+1)'(HRAM_BASE);
    localparam logic [AW:0] HRAM_HI   = (AW+1)'(HRAM_END);
    localparam logic [AW:0] IFR_A     = (AW+1)'(c_ifr_addr);
    localparam logic [AW:0] TIM_LO    = (AW+1)'(c_tim_lo);
    localparam logic [AW:0] TIM_HI    = (AW+1)'(c_tim_hi);
    localparam logic [AW:0] IE_A      = (AW+1)'(c_ie_addr);
    localparam logic [AW:0] IO_LO     = (AW+1)'(c_io_lo);
    localparam logic [AW:0] IO_HI     = (AW+1)'(c_io_hi);
    localparam logic        BOOT1_EN  = (BOOT_SIZE != 0);
    localparam logic        BOOT2_EN  = (BOOT2_SIZE != 0);

    logic [AW:0] addr;
    logic        in_boot;

    assign addr    = {1'b0, a};
    assign in_boot = (BOOT1_EN && (addr < BOOT1_LIM)) ||
                     (BOOT2_EN && (addr >= BOOT2_LO) && (addr <= BOOT2_HI));

    always_comb begin
        region = REG_EXT;
        if (in_boot && !boot_locked)                 region = REG_BOOT;
        else if (addr >= HRAM_LO && addr <= HRAM_HI) region = REG_HRAM;
        else if (addr == IFR_A)                      region = REG_IFR;
        else if (addr >= TIM_LO && addr <= TIM_HI)   region = REG_TIMER;
        else if (addr == IE_A)                       region = REG_IE;
        else if (addr >= IO_LO && addr <= IO_HI)     region = REG_IO;
    end

endmodule : sys_addr_region
`default_nettype wire

// File: rtl/sys_addr_map.sv
`default_nettype none
// ============================================================================
// Module      : sys_addr_map
// Description : CPU address decoder and bus-access sequencer. Latches a
//               one-hot region select per request, drives read/write strobes
//               with per-region wait states, and acks with a one-cycle pulse.
//               Owns the sticky boot-lock and the 2-bit test-mode registers.
//   clk     in  system clock
//   nreset  in  synchronous active-low reset
//   bus     slave modport of sys_addr_map_if (req/ack, sel, strobes, rdata,
//           boot_locked, test_bits)
// Revision    : 1.0 - initial release
// ============================================================================
module sys_addr_map
    import sys_addr_map_pkg::*;
#(
    parameter int          AW         = 16,
    parameter int          DW         = 8,
    parameter int unsigned BOOT_SIZE  = 256,
    parameter int unsigned BOOT2_BASE = 'h0200,
    parameter int unsigned BOOT2_SIZE = 0,
    parameter int unsigned LOCK_ADDR  = c_lock_addr,
    parameter int unsigned TEST_ADDR  = c_test_addr,
    parameter int unsigned HRAM_BASE  = c_hram_base,
    parameter int unsigned HRAM_END   = c_hram_end,
    parameter int unsigned WS_EXT     = 2
) (
    input  logic           clk,
    input  logic           nreset,
    sys_addr_map_if.slave  bus
);

    generate
        if (WS_EXT > 15) begin : g_ws_check
            $error("sys_addr_map: WS_EXT must be 0..15");
        end
        if (AW < 16) begin : g_aw_check
            $error("sys_addr_map: AW must be >= 16");
        end
        if (DW < 2) begin : g_dw_check
            $error("sys_addr_map: DW must be >= 2");
        end
    endgenerate

    localparam logic [3:0]    WS_LOAD = 4'(WS_EXT);
    localparam logic          HAS_WS  = (WS_EXT != 0);
    localparam logic [AW-1:0] LOCK_A  = AW'(LOCK_ADDR);
    localparam logic [AW-1:0] TEST_A  = AW'(TEST_ADDR);

    state_t         state, state_nxt;
    logic [3:0]     cnt, cnt_nxt;
    logic [SEL_W-1:0] sel_q;
    logic           we_q;
    logic           ext_q;
    logic           lock_hit;
    logic           test_hit;
    logic [1:0]     wd_q;
    logic           boot_locked_q;
    logic [1:0]     test_bits_q;
    region_t        dec_region;
    logic           capture;
    logic           unused_wdata;

    // Only the low two data bits are ever consumed.
    assign unused_wdata = ^bus.wdata;

    sys_addr_region #(
        .AW         (AW),
        .BOOT_SIZE  (BOOT_SIZE),
        .BOOT2_BASE (BOOT2_BASE),
        .BOOT2_SIZE (BOOT2_SIZE),
        .HRAM_BASE  (HRAM_BASE),
        .HRAM_END   (HRAM_END)
    ) u_region (
        .a           (bus.a),
        .boot_locked (boot_locked_q),
        .region      (dec_region)
    );

    assign capture = (state == ST_IDLE) && bus.req;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (bus.req) state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (ext_q && HAS_WS) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = WS_LOAD;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_WAIT: begin
                // Counter holds the remaining WAIT cycles including this one.
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request capture and register-file updates. The lock is sampled by the
    // decoder at capture, so a lock write only affects later requests.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            sel_q         <= '0;
            we_q          <= 1'b0;
            ext_q         <= 1'b0;
            lock_hit      <= 1'b0;
            test_hit      <= 1'b0;
            wd_q          <= '0;
            boot_locked_q <= 1'b0;
            test_bits_q   <= '0;
        end else begin
            if (capture) begin
                sel_q    <= region_to_sel(dec_region);
                we_q     <= bus.we;
                ext_q    <= (dec_region == REG_EXT);
                lock_hit <= (bus.a == LOCK_A);
                test_hit <= (bus.a == TEST_A);
                wd_q     <= bus.wdata[1:0];
            end else if (state_nxt == ST_DONE) begin
                sel_q <= '0;
            end

            if (state == ST_DONE && we_q) begin
                if (lock_hit && wd_q[0]) boot_locked_q <= 1'b1;
                if (test_hit && bus.test_en) test_bits_q <= wd_q;
            end
        end
    end

    always_comb begin
        bus.rdata    = '0;
        bus.rdata_oe = 1'b0;
        if (state == ST_DONE && !we_q) begin
            if (lock_hit) begin
                bus.rdata    = {{(DW-1){1'b1}}, boot_locked_q};
                bus.rdata_oe = 1'b1;
            end else if (test_hit) begin
                bus.rdata    = DW'(test_bits_q);
                bus.rdata_oe = 1'b1;
            end
        end
    end

    assign bus.ack         = (state == ST_DONE);
    assign bus.sel         = sel_q;
    assign bus.rd_stb      = ((state == ST_ACCESS) || (state == ST_WAIT)) && !we_q;
    assign bus.wr_stb      = ((state == ST_ACCESS) || (state == ST_WAIT)) && we_q;
    assign bus.boot_locked = boot_locked_q;
    assign bus.test_bits   = test_bits_q;

endmodule : sys_addr_map
`default_nettype wire

// File: tb/tb_sys_addr_map.sv
`default_nettype none
// ============================================================================
// Module      : tb_sys_addr_map
// Description : Scoreboard bench for sys_addr_map (WS_EXT=2, BOOT2_SIZE=0x700).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_addr_map;

    typedef struct {
        logic [6:0] sel;
        int         lat;
        logic       oe;
        logic [7:0] rdata;
    } exp_t;

    logic clk;
    logic nreset;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    sys_addr_map_if #(.AW(16), .DW(8)) bus ();

    sys_addr_map #(
        .AW         (16),
        .DW         (8),
        .BOOT_SIZE  (256),
        .BOOT2_BASE ('h0200),
        .BOOT2_SIZE ('h0700),
        .WS_EXT     (2)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: capture sel on the first strobe cycle, count cycles, and
    // compare against the scoreboard when ack appears.
    initial begin : monitor
        logic       in_acc;
        logic [6:0] cap_sel;
        int         cnt;
        exp_t       e;
        in_acc = 1'b0;
        cap_sel = '0;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                in_acc = 1'b0;
            end else if (bus.ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sel", {25'd0, cap_sel}, {25'd0, e.sel});
                    chk("sel_onehot", {31'd0, $onehot(cap_sel)}, 32'd1);
                    chk("latency", cnt + 1, e.lat);
                    chk("rdata_oe", {31'd0, bus.rdata_oe}, {31'd0, e.oe});
                    chk("rdata", {24'd0, bus.rdata}, {24'd0, e.rdata});
                    chk("idle_at_ack", {23'd0, bus.sel, bus.rd_stb, bus.wr_stb}, 32'd0);
                end
                in_acc = 1'b0;
            end else if (bus.rd_stb || bus.wr_stb) begin
                if (!in_acc) begin
                    in_acc  = 1'b1;
                    cap_sel = bus.sel;
                    cnt     = 1;
                end else begin
                    cnt++;
                end
            end
        end
    end

    task automatic do_acc(input logic w, input logic [15:0] addr, input logic [7:0] wd,
                          input logic [6:0] es, input int el, input logic eo,
                          input logic [7:0] er);
        exp_t e;
        int   n;
        e.sel = es; e.lat = el; e.oe = eo; e.rdata = er;
        exp_q.push_back(e);
        bus.we = w; bus.a = addr; bus.wdata = wd; bus.req = 1'b1;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (bus.ack) break;
        end
        chk("ack_seen", {31'd0, bus.ack}, 32'd1);
        bus.req = 1'b0;
        @(negedge clk);
    endtask

    localparam logic [6:0] S_BOOT = 7'h01, S_HRAM = 7'h02, S_IFR = 7'h04,
                           S_TIM = 7'h08, S_IE = 7'h10, S_IO = 7'h20, S_EXT = 7'h40;

    initial begin : driver
        int acks;
        nreset = 1'b0;
        bus.req = 1'b0; bus.we = 1'b0; bus.a = '0; bus.wdata = '0; bus.test_en = 1'b0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        chk("reset_outs", {21'd0, bus.ack, bus.sel, bus.rd_stb, bus.wr_stb, bus.rdata_oe}, 32'd0);
        chk("reset_rdata", {24'd0, bus.rdata}, 32'd0);
        chk("reset_regs", {29'd0, bus.boot_locked, bus.test_bits}, 32'd0);

        // Boot windows, unlocked
        do_acc(1'b0, 16'h0010, 8'h00, S_BOOT, 2, 1'b0, 8'h00);
        do_acc(1'b0, 16'h0200, 8'h00, S_BOOT, 2, 1'b0, 8'h00);
        do_acc(1'b0, 16'h08FF, 8'h00, S_BOOT, 2, 1'b0, 8'h00);
        do_acc(1'b0, 16'h0900, 8'h00, S_EXT,  4, 1'b0, 8'h00);
        do_acc(1'b0, 16'h0100, 8'h00, S_EXT,  4, 1'b0, 8'h00);

        // Region sweep
        do_acc(1'b0, 16'hFF0F, 8'h00, S_IFR,  2, 1'b0, 8'h00);
        do_acc(1'b0, 16'hFF05, 8'h00, S_TIM,  2, 1'b0, 8'h00);
        do_acc(1'b0, 16'hFF80, 8'h00, S_HRAM, 2, 1'b0, 8'h00);
        do_acc(1'b0, 16'hFFFE, 8'h00, S_HRAM, 2, 1'b0, 8'h00);
        do_acc(1'b0, 16'hFFFF, 8'h00, S_IE,   2, 1'b0, 8'h00);
        do_acc(1'b0, 16'hFF40, 8'h00, S_IO,   2, 1'b0, 8'h00);
        do_acc(1'b1, 16'hC000, 8'h5A, S_EXT,  4, 1'b0, 8'h00);

        // Test-mode register
        bus.test_en = 1'b0;
        do_acc(1'b1, 16'hFF60, 8'h03, S_IO, 2, 1'b0, 8'h00);
        chk("test_bits_gated", {30'd0, bus.test_bits}, 32'd0);
        bus.test_en = 1'b1;
        do_acc(1'b1, 16'hFF60, 8'h03, S_IO, 2, 1'b0, 8'h00);
        chk("test_bits_set", {30'd0, bus.test_bits}, 32'd3);
        bus.test_en = 1'b0;
        do_acc(1'b0, 16'hFF60, 8'h00, S_IO, 2, 1'b1, 8'h03);

        // Boot lock
        do_acc(1'b0, 16'hFF50, 8'h00, S_IO, 2, 1'b1, 8'hFE);
        do_acc(1'b1, 16'hFF50, 8'h01, S_IO, 2, 1'b0, 8'h00);
        chk("lock_set", {31'd0, bus.boot_locked}, 32'd1);
        do_acc(1'b0, 16'h0010, 8'h00, S_EXT, 4, 1'b0, 8'h00);
        do_acc(1'b0, 16'h0200, 8'h00, S_EXT, 4, 1'b0, 8'h00);
        do_acc(1'b1, 16'hFF50, 8'h00, S_IO, 2, 1'b0, 8'h00);
        chk("lock_sticky", {31'd0, bus.boot_locked}, 32'd1);
        do_acc(1'b0, 16'hFF50, 8'h00, S_IO, 2, 1'b1, 8'hFF);

        // Reset during WAIT of an external access
        bus.we = 1'b0; bus.a = 16'hC000; bus.req = 1'b1;
        @(negedge clk);
        chk("abort_access", {31'd0, bus.rd_stb}, 32'd1);
        @(negedge clk);
        chk("abort_wait", {25'd0, bus.sel}, {25'd0, S_EXT});
        nreset = 1'b0;
        bus.req = 1'b0;
        @(negedge clk);
        chk("abort_outs", {28'd0, bus.ack, bus.rd_stb, bus.wr_stb, bus.rdata_oe}, 32'd0);
        chk("abort_sel", {25'd0, bus.sel}, 32'd0);
        chk("abort_regs", {29'd0, bus.boot_locked, bus.test_bits}, 32'd0);
        nreset = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ack) acks++;
        end
        chk("abort_no_ack", acks, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sys_addr_map
`default_nettype wire
